// File: rtl/ddr3_pkg.sv
// Shared widths, FSM encoding and command payload for the DDR3 Avalon arbiter.
package ddr3_pkg;

  localparam int unsigned ADDR_W = 26;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned SIZE_W = 3;

  // FSM encoding kept as plain constants so older blocks can share it
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RD_CMD   = 2'd1;
  localparam logic [1:0] ST_WR_BURST = 2'd2;

  // Command half of the Avalon output register
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [SIZE_W-1:0] size;
  } avl_cmd_t;

  // A zero-length write burst is issued as a single beat
  function automatic logic [SIZE_W-1:0] eff_beats(input logic [SIZE_W-1:0] size);
    return (size == '0) ? SIZE_W'(1) : size;
  endfunction

endpackage

// File: rtl/ddr3_rd_credit.sv
// Outstanding read-beat tracker: counter, credit check and sticky underflow flag.
module ddr3_rd_credit
  import ddr3_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 32,
  parameter int unsigned OSTD_W          = 6
) (
  input  logic              ddr3_clk,
  input  logic              ddr3_reset_n,
  input  logic              i_cmd_accept,
  input  logic [SIZE_W-1:0] i_cmd_size,
  input  logic              i_rd_valid,
  input  logic [SIZE_W-1:0] i_pend_size,
  input  logic [SIZE_W-1:0] i_req_size,
  output logic              o_credit_ok_c,
  output logic [OSTD_W-1:0] o_outstanding,
  output logic              o_underflow
);

  localparam int unsigned SUM_W = OSTD_W + 1;

  logic [OSTD_W-1:0] r_cnt;
  logic              r_underflow;
  logic [SUM_W-1:0]  w_need;
  logic [SUM_W-1:0]  w_cnt_nxt;
  logic              w_dec;

  // Credit includes a read still sitting in the output register, so a
  // back-to-back grant cannot over-commit before the counter catches up
  always_comb begin
    w_need        = SUM_W'(r_cnt) + SUM_W'(i_pend_size) + SUM_W'(i_req_size);
    o_credit_ok_c = (w_need <= SUM_W'(MAX_OUTSTANDING));
    w_dec         = i_rd_valid && (r_cnt != '0);
    w_cnt_nxt     = SUM_W'(r_cnt)
                  + (i_cmd_accept ? SUM_W'(i_cmd_size) : SUM_W'(0))
                  - SUM_W'(w_dec);
  end

  // Counter update; a data beat with nothing in flight saturates and flags
  always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
    if (!ddr3_reset_n) begin
      r_cnt       <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt[OSTD_W-1:0];
      r_underflow <= r_underflow | (i_rd_valid && (r_cnt == '0));
    end
  end

  assign o_outstanding = r_cnt;
  assign o_underflow   = r_underflow;

endmodule

// File: rtl/ddr3_avl_arbiter.sv
// Read/write arbiter in front of the DDR3 Avalon-MM port: read priority,
// write starvation bound, whole write bursts, read credit tracking.
module ddr3_avl_arbiter
  import ddr3_pkg::*;
#(
  parameter int unsigned WR_STARVE_MAX   = 16,
  parameter int unsigned MAX_OUTSTANDING = 32,
  parameter int unsigned OSTD_W          = 6
) (
  input  logic              ddr3_clk,
  input  logic              ddr3_reset_n,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [SIZE_W-1:0] rd_size,
  output logic              rd_ack,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [SIZE_W-1:0] wr_size,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              avl_ready,
  output logic              avl_read_req,
  output logic              avl_write_req,
  output logic              avl_burstbegin,
  output logic [ADDR_W-1:0] avl_addr,
  output logic [SIZE_W-1:0] avl_size,
  output logic [DATA_W-1:0] avl_wr_data,
  input  logic              avl_rd_valid,
  output logic [OSTD_W-1:0] rd_outstanding,
  output logic              ostd_underflow
);

  localparam int unsigned STARVE_W = $clog2(WR_STARVE_MAX + 1);

  logic [1:0]          r_state;
  logic                r_run;
  logic                r_rd_req;
  logic                r_wr_req;
  logic                r_bb;
  avl_cmd_t            r_cmd;
  logic [DATA_W-1:0]   r_wr_data;
  logic [SIZE_W-1:0]   r_beats_left;
  logic [STARVE_W-1:0] r_starve;

  logic [1:0]          w_state_nxt;
  logic                w_arb_en;
  logic                w_rd_grant;
  logic                w_wr_grant;
  logic                w_wr_next_beat;
  logic                w_starved;
  logic                w_credit_ok;
  logic [SIZE_W-1:0]   w_pend_size;

  // Next-state and grant decode; arbitration only when the output register
  // is empty (IDLE) or being emptied by avl_ready at the end of a command/burst
  always_comb begin
    w_state_nxt    = r_state;
    w_arb_en       = 1'b0;
    w_rd_grant     = 1'b0;
    w_wr_grant     = 1'b0;
    w_wr_next_beat = 1'b0;
    w_starved      = wr_req && (r_starve == STARVE_W'(WR_STARVE_MAX));
    case (r_state)
      ST_IDLE:     w_arb_en = r_run;
      ST_RD_CMD:   w_arb_en = avl_ready;
      ST_WR_BURST: begin
        if (r_beats_left == '0) begin
          w_arb_en = avl_ready;
        end else begin
          w_wr_next_beat = wr_req && (!r_wr_req || avl_ready);
        end
      end
      default:     w_state_nxt = ST_IDLE;
    endcase
    w_rd_grant = w_arb_en && rd_req && w_credit_ok && !w_starved;
    w_wr_grant = w_arb_en && !w_rd_grant && wr_req;
    if (w_rd_grant) begin
      w_state_nxt = ST_RD_CMD;
    end else if (w_wr_grant) begin
      w_state_nxt = ST_WR_BURST;
    end else if (w_arb_en) begin
      w_state_nxt = ST_IDLE;
    end
  end

  // FSM state register
  always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
    if (!ddr3_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Holds off grants (and thus acks) until the first edge after reset release
  always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
    if (!ddr3_reset_n) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  // Avalon output register: load on grant/next beat, drop on accept, else hold
  always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
    if (!ddr3_reset_n) begin
      r_rd_req     <= 1'b0;
      r_wr_req     <= 1'b0;
      r_bb         <= 1'b0;
      r_cmd        <= '0;
      r_wr_data    <= '0;
      r_beats_left <= '0;
    end else if (w_rd_grant) begin
      r_rd_req     <= 1'b1;
      r_wr_req     <= 1'b0;
      r_bb         <= 1'b1;
      r_cmd        <= '{addr: rd_addr, size: rd_size};
    end else if (w_wr_grant) begin
      r_rd_req     <= 1'b0;
      r_wr_req     <= 1'b1;
      r_bb         <= 1'b1;
      r_cmd        <= '{addr: wr_addr, size: wr_size};
      r_wr_data    <= wr_data;
      r_beats_left <= eff_beats(wr_size) - SIZE_W'(1);
    end else if (w_wr_next_beat) begin
      r_wr_req     <= 1'b1;
      r_bb         <= 1'b0;
      r_wr_data    <= wr_data;
      r_beats_left <= r_beats_left - SIZE_W'(1);
    end else begin
      r_bb         <= 1'b0;
      if (avl_ready) begin
        r_rd_req <= 1'b0;
        r_wr_req <= 1'b0;
      end
    end
  end

  // Count read grants taken while a write waits; a write grant clears it
  always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
    if (!ddr3_reset_n) begin
      r_starve <= '0;
    end else if (w_wr_grant) begin
      r_starve <= '0;
    end else if (w_rd_grant && wr_req && (r_starve != STARVE_W'(WR_STARVE_MAX))) begin
      r_starve <= r_starve + STARVE_W'(1);
    end
  end

  assign w_pend_size = r_rd_req ? r_cmd.size : '0;

  ddr3_rd_credit #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .OSTD_W          (OSTD_W)
  ) u_rd_credit (
    .ddr3_clk      (ddr3_clk),
    .ddr3_reset_n  (ddr3_reset_n),
    .i_cmd_accept  (r_rd_req && avl_ready),
    .i_cmd_size    (r_cmd.size),
    .i_rd_valid    (avl_rd_valid),
    .i_pend_size   (w_pend_size),
    .i_req_size    (rd_size),
    .o_credit_ok_c (w_credit_ok),
    .o_outstanding (rd_outstanding),
    .o_underflow   (ostd_underflow)
  );

  // Acks are the handshake completing the master's held request this cycle
  assign rd_ack         = w_rd_grant;
  assign wr_ack         = w_wr_grant || w_wr_next_beat;
  assign avl_read_req   = r_rd_req;
  assign avl_write_req  = r_wr_req;
  assign avl_burstbegin = r_bb;
  assign avl_addr       = r_cmd.addr;
  assign avl_size       = r_cmd.size;
  assign avl_wr_data    = r_wr_data;

endmodule

// File: tb/tb_ddr3_avl_arbiter.sv
// Directed self-checking bench for ddr3_avl_arbiter.
module tb_ddr3_avl_arbiter;
  import ddr3_pkg::*;

  localparam int unsigned OSTD_W = 6;

  logic              ddr3_clk;
  logic              ddr3_reset_n;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [SIZE_W-1:0] rd_size;
  logic              rd_ack;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [SIZE_W-1:0] wr_size;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              avl_ready;
  logic              avl_read_req;
  logic              avl_write_req;
  logic              avl_burstbegin;
  logic [ADDR_W-1:0] avl_addr;
  logic [SIZE_W-1:0] avl_size;
  logic [DATA_W-1:0] avl_wr_data;
  logic              avl_rd_valid;
  logic [OSTD_W-1:0] rd_outstanding;
  logic              ostd_underflow;

  int n_checks;
  int n_fail;
  logic [DATA_W-1:0] wd [4];

  ddr3_avl_arbiter dut (
    .ddr3_clk       (ddr3_clk),
    .ddr3_reset_n   (ddr3_reset_n),
    .rd_req         (rd_req),
    .rd_addr        (rd_addr),
    .rd_size        (rd_size),
    .rd_ack         (rd_ack),
    .wr_req         (wr_req),
    .wr_addr        (wr_addr),
    .wr_size        (wr_size),
    .wr_data        (wr_data),
    .wr_ack         (wr_ack),
    .avl_ready      (avl_ready),
    .avl_read_req   (avl_read_req),
    .avl_write_req  (avl_write_req),
    .avl_burstbegin (avl_burstbegin),
    .avl_addr       (avl_addr),
    .avl_size       (avl_size),
    .avl_wr_data    (avl_wr_data),
    .avl_rd_valid   (avl_rd_valid),
    .rd_outstanding (rd_outstanding),
    .ostd_underflow (ostd_underflow)
  );

  initial ddr3_clk = 1'b0;
  always #5 ddr3_clk = ~ddr3_clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge ddr3_clk);
    #1;
  endtask

  task automatic do_reset();
    rd_req       = 1'b0;
    rd_addr      = '0;
    rd_size      = '0;
    wr_req       = 1'b0;
    wr_addr      = '0;
    wr_size      = '0;
    wr_data      = '0;
    avl_ready    = 1'b0;
    avl_rd_valid = 1'b0;
    ddr3_reset_n = 1'b0;
    step();
    step();
    ddr3_reset_n = 1'b1;
    step();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, wbeat, bb_cnt, acks, rgr;
    bit seen_wr, rd_seen, rd_early, both, got_wack, wseen;
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 4; i++) wd[i] = {32'(i + 1), 32'hCAFE_F00D, 32'(i * 3), 32'h5A5A_0000};

    // 1: reset state and single read
    do_reset();
    @(negedge ddr3_clk);
    check_eq("rst_rd_req", avl_read_req, 0);
    check_eq("rst_wr_req", avl_write_req, 0);
    check_eq("rst_bb", avl_burstbegin, 0);
    check_eq("rst_addr", avl_addr, 0);
    check_eq("rst_ostd", rd_outstanding, 0);
    check_eq("rst_uflow", ostd_underflow, 0);
    step();
    rd_req = 1; rd_addr = 26'h100; rd_size = 3'd4; avl_ready = 1;
    @(negedge ddr3_clk);
    check_eq("t1_rd_ack", rd_ack, 1);
    check_eq("t1_no_req_yet", avl_read_req, 0);
    step();
    rd_req = 0;
    @(negedge ddr3_clk);
    check_eq("t1_read_req", avl_read_req, 1);
    check_eq("t1_bb", avl_burstbegin, 1);
    check_eq("t1_addr", avl_addr, 26'h100);
    check_eq("t1_size", avl_size, 4);
    step();
    @(negedge ddr3_clk);
    check_eq("t1_read_req_drop", avl_read_req, 0);
    check_eq("t1_ostd4", rd_outstanding, 4);
    step();
    avl_rd_valid = 1;
    repeat (4) step();
    avl_rd_valid = 0;
    @(negedge ddr3_clk);
    check_eq("t1_ostd0", rd_outstanding, 0);
    check_eq("t1_uflow", ostd_underflow, 0);

    // 2: write burst of 4 with avl_ready toggling, read arriving mid-burst
    do_reset();
    acc = 0; wbeat = 0; bb_cnt = 0;
    seen_wr = 0; rd_seen = 0; rd_early = 0; both = 0;
    wr_req = 1; wr_addr = 26'h200; wr_size = 3'd4; wr_data = wd[0];
    for (int cyc = 0; cyc < 40 && !rd_seen; cyc++) begin
      avl_ready = (cyc % 2 == 0);
      if (acc >= 1) begin rd_req = 1; rd_addr = 26'h300; rd_size = 3'd2; end
      @(negedge ddr3_clk);
      if (avl_write_req && !seen_wr) begin
        check_eq("t2_bb_first", avl_burstbegin, 1);
        seen_wr = 1;
      end
      if (avl_burstbegin) bb_cnt++;
      if (avl_read_req && avl_write_req) both = 1;
      if (avl_write_req && avl_ready) begin
        if (acc < 4) check_eq($sformatf("t2_beat%0d", acc), avl_wr_data, wd[acc]);
        acc++;
      end
      got_wack = wr_ack;
      if (rd_ack) begin
        rd_seen = 1;
        if (acc < 4) rd_early = 1;
      end
      step();
      if (got_wack) begin
        wbeat++;
        if (wbeat < 4) wr_data = wd[wbeat];
        else wr_req = 0;
      end
      if (rd_seen) rd_req = 0;
    end
    check_eq("t2_beats", acc, 4);
    check_eq("t2_rd_granted", rd_seen, 1);
    check_eq("t2_rd_early", rd_early, 0);
    check_eq("t2_bb_count", bb_cnt, 1);
    check_eq("t2_both_req", both, 0);
    avl_ready = 1;
    @(negedge ddr3_clk);
    check_eq("t2_rd_after", avl_read_req, 1);
    check_eq("t2_rd_addr", avl_addr, 26'h300);
    check_eq("t2_rd_bb", avl_burstbegin, 1);
    step();
    @(negedge ddr3_clk);
    check_eq("t2_ostd2", rd_outstanding, 2);

    // 3: credit limit with no data return
    do_reset();
    acks = 0;
    avl_ready = 1; rd_req = 1; rd_size = 3'd4; rd_addr = 26'h1000;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge ddr3_clk);
      if (rd_ack) acks++;
      step();
    end
    check_eq("t3_acks8", acks, 8);
    check_eq("t3_ostd32", rd_outstanding, 32);
    for (int i = 0; i < 4; i++) begin
      avl_rd_valid = 1;
      @(negedge ddr3_clk);
      if (rd_ack) acks++;
      step();
    end
    avl_rd_valid = 0;
    check_eq("t3_held", acks, 8);
    @(negedge ddr3_clk);
    check_eq("t3_ack_after_return", rd_ack, 1);
    step();
    rd_req = 0;
    step();
    check_eq("t3_ostd_refill", rd_outstanding, 32);

    // 4: write starvation bound
    do_reset();
    rgr = 0; wseen = 0;
    avl_ready = 1; rd_req = 1; rd_size = 3'd1; rd_addr = 26'h2000;
    wr_req = 1; wr_addr = 26'h400; wr_size = 3'd1; wr_data = wd[2];
    for (int cyc = 0; cyc < 40 && !wseen; cyc++) begin
      @(negedge ddr3_clk);
      if (rd_ack) rgr++;
      if (wr_ack) begin
        wseen = 1;
        check_eq("t4_rd_with_wr", rd_ack, 0);
      end
      step();
    end
    wr_req = 0; rd_req = 0;
    check_eq("t4_wr_seen", wseen, 1);
    check_eq("t4_rd_grants", rgr, 16);
    @(negedge ddr3_clk);
    check_eq("t4_wr_req", avl_write_req, 1);
    check_eq("t4_wr_addr", avl_addr, 26'h400);
    step();

    // 5: simultaneous accept + return, then underflow
    do_reset();
    avl_ready = 1; rd_req = 1; rd_size = 3'd5; rd_addr = 26'h3000;
    @(negedge ddr3_clk);
    check_eq("t5_ack5", rd_ack, 1);
    step();
    rd_req = 0;
    step();
    check_eq("t5_ostd5", rd_outstanding, 5);
    rd_req = 1; rd_size = 3'd4;
    @(negedge ddr3_clk);
    check_eq("t5_ack4", rd_ack, 1);
    step();
    rd_req = 0; avl_rd_valid = 1;
    step();
    avl_rd_valid = 0;
    check_eq("t5_ostd8", rd_outstanding, 8);
    avl_rd_valid = 1;
    repeat (8) step();
    avl_rd_valid = 0;
    check_eq("t5_ostd0", rd_outstanding, 0);
    check_eq("t5_uflow0", ostd_underflow, 0);
    avl_rd_valid = 1;
    step();
    avl_rd_valid = 0;
    check_eq("t5_sat0", rd_outstanding, 0);
    check_eq("t5_uflow1", ostd_underflow, 1);
    step();
    check_eq("t5_uflow_sticky", ostd_underflow, 1);

    // 6: reset in the middle of a write burst
    do_reset();
    wbeat = 0;
    avl_ready = 1; wr_req = 1; wr_addr = 26'h500; wr_size = 3'd4; wr_data = wd[0];
    for (int cyc = 0; cyc < 10 && wbeat < 2; cyc++) begin
      @(negedge ddr3_clk);
      got_wack = wr_ack;
      step();
      if (got_wack) begin
        wbeat++;
        wr_data = wd[wbeat];
      end
    end
    check_eq("t6_pre_wr", avl_write_req, 1);
    check_eq("t6_pre_data", avl_wr_data, wd[1]);
    #2;
    ddr3_reset_n = 0;
    #1;
    check_eq("t6_rst_wr", avl_write_req, 0);
    check_eq("t6_rst_data", avl_wr_data, 0);
    check_eq("t6_rst_addr", avl_addr, 0);
    check_eq("t6_rst_wr_ack", wr_ack, 0);
    wr_req = 0;
    step();
    ddr3_reset_n = 1;
    step();
    step();
    check_eq("t6_post_wr", avl_write_req, 0);
    rd_req = 1; rd_size = 3'd1; rd_addr = 26'h600;
    @(negedge ddr3_clk);
    check_eq("t6_idle_rd_ack", rd_ack, 1);
    step();
    rd_req = 0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
